// File: rtl/lift_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : lift_dispatcher
//  Purpose  : Command side of a three-floor lift. Latches call buttons, runs
//             a SCAN (collective) policy and issues one-cycle up/down pulses
//             to the floor controller, timing the door at each served floor.
//  Ports    : clk        - system clock, rising edge
//             reset      - asynchronous active-low reset
//             call[2:0]  - call buttons, bit i requests floor code i+1
//             floor_in   - floor code from the controller (1..3, 0 illegal)
//             up / down  - one-cycle move commands (never high together)
//             door_open  - door open at the current floor
//             dir_up     - current SCAN direction (1 = up, 0 = down)
//             pending    - latched outstanding calls
//             busy       - FSM not in IDLE
//             fault      - sticky illegal-floor flag
//  Revision : 1.0 - initial release
// ============================================================================
module lift_dispatcher #(
    parameter int DOOR_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] call,
    input  logic [1:0] floor_in,
    output logic       up,
    output logic       down,
    output logic       door_open,
    output logic       dir_up,
    output logic [2:0] pending,
    output logic       busy,
    output logic       fault
);

    localparam int MAX_CYCLES = (DOOR_CYCLES > SETTLE_CYCLES) ? DOOR_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // Counters load "cycles - 1" and exit on zero.
    localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MOVE_UP = 3'd1,
        S_MOVE_DN = 3'd2,
        S_SETTLE  = 3'd3,
        S_DOOR    = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             dir_d;
    logic [2:0]       clr;
    logic [2:0]       floor_hot;
    logic             above;
    logic             below;
    logic             here;

    // Call position relative to the car. An illegal floor code yields no
    // one-hot bit, so nothing is ever cleared against floor 0.
    always_comb begin
        floor_hot = 3'b000;
        above     = 1'b0;
        below     = 1'b0;
        case (floor_in)
            2'd1: begin
                floor_hot = 3'b001;
                above     = pending[1] | pending[2];
            end
            2'd2: begin
                floor_hot = 3'b010;
                above     = pending[2];
                below     = pending[0];
            end
            2'd3: begin
                floor_hot = 3'b100;
                below     = pending[0] | pending[1];
            end
            default: begin
                floor_hot = 3'b000;
            end
        endcase
        here = |(pending & floor_hot);
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        dir_d   = dir_up;
        clr     = 3'b000;
        case (state)
            S_IDLE: begin
                if (floor_in == 2'd0) begin
                    state_d = S_FAULT;
                end else if (here) begin
                    state_d = S_DOOR;
                    cnt_d   = DOOR_LAST;
                    clr     = floor_hot;
                end else if (dir_up && above) begin
                    state_d = S_MOVE_UP;
                end else if (!dir_up && below) begin
                    state_d = S_MOVE_DN;
                end else if (above) begin
                    // Nothing ahead in the old direction: reverse
                    state_d = S_MOVE_UP;
                    dir_d   = 1'b1;
                end else if (below) begin
                    state_d = S_MOVE_DN;
                    dir_d   = 1'b0;
                end
            end
            S_MOVE_UP, S_MOVE_DN: begin
                state_d = S_SETTLE;
                cnt_d   = SETTLE_LAST;
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            S_DOOR: begin
                // Calls for this floor are absorbed while the door is open
                clr = floor_hot;
                if (cnt == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs. Outputs decode the next state so each
    // command lines up with the cycle the FSM spends in that state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            dir_up    <= 1'b1;
            pending   <= 3'b000;
            up        <= 1'b0;
            down      <= 1'b0;
            door_open <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            dir_up    <= dir_d;
            pending   <= (pending | call) & ~clr;
            up        <= (state_d == S_MOVE_UP);
            down      <= (state_d == S_MOVE_DN);
            door_open <= (state_d == S_DOOR);
            busy      <= (state_d != S_IDLE);
            fault     <= (state_d == S_FAULT);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lift_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lift_dispatcher
//  Purpose  : Self-checking bench for lift_dispatcher. A behavioural model
//             tracks the call set, SCAN direction and the remaining length of
//             the current action (door or move+settle) as a single countdown.
//             A simple floor-controller plant reacts to the up/down pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lift_dispatcher;

    localparam int DOOR_CYCLES   = 4;
    localparam int SETTLE_CYCLES = 2;
    localparam int A_NONE = 0;
    localparam int A_UP   = 1;
    localparam int A_DN   = 2;
    localparam int A_DOOR = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] call = 3'b000;
    logic [1:0] floor_in = 2'd1;
    logic       up, down, door_open, dir_up, busy, fault;
    logic [2:0] pending;

    int n_checks = 0;
    int n_fail   = 0;
    bit stuck    = 1'b0;

    // Behavioural model
    logic [2:0] m_pend;
    bit         m_dir;
    bit         m_fault;
    int         m_act;
    int         m_left;

    lift_dispatcher #(
        .DOOR_CYCLES  (DOOR_CYCLES),
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .call     (call),
        .floor_in (floor_in),
        .up       (up),
        .down     (down),
        .door_open(door_open),
        .dir_up   (dir_up),
        .pending  (pending),
        .busy     (busy),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pend  = 3'b000;
        m_dir   = 1'b1;
        m_fault = 1'b0;
        m_act   = A_NONE;
        m_left  = 0;
    endtask

    // One clock edge of the reference: either continue the current action or,
    // when free, pick the next one from the SCAN rules.
    task automatic model_edge();
        logic [2:0] clr;
        int         f;
        bit         ab;
        bit         bl;
        if (!reset) begin
            model_reset();
            return;
        end
        f   = int'(floor_in);
        clr = 3'b000;
        if (m_fault) begin
            // calls still accumulate
        end else if (m_left > 0) begin
            if (m_act == A_DOOR && f != 0) clr = 3'b001 << (f - 1);
            m_left--;
            if (m_left == 0) m_act = A_NONE;
        end else if (f == 0) begin
            m_fault = 1'b1;
        end else begin
            ab = 1'b0;
            bl = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (m_pend[i] && i > f - 1) ab = 1'b1;
                if (m_pend[i] && i < f - 1) bl = 1'b1;
            end
            if (m_pend[f-1]) begin
                m_act  = A_DOOR;
                m_left = DOOR_CYCLES;
                clr    = 3'b001 << (f - 1);
            end else if (ab && (m_dir || !bl)) begin
                m_act  = A_UP;
                m_left = SETTLE_CYCLES + 1;
                m_dir  = 1'b1;
            end else if (bl) begin
                m_act  = A_DN;
                m_left = SETTLE_CYCLES + 1;
                m_dir  = 1'b0;
            end
        end
        m_pend = (m_pend | call) & ~clr;
    endtask

    function automatic bit exp_up();
        return (m_act == A_UP) && (m_left == SETTLE_CYCLES + 1);
    endfunction
    function automatic bit exp_dn();
        return (m_act == A_DN) && (m_left == SETTLE_CYCLES + 1);
    endfunction
    function automatic bit exp_door();
        return (m_act == A_DOOR);
    endfunction
    function automatic bit exp_busy();
        return m_fault || (m_left > 0);
    endfunction

    // Advance one clock, update the model, then let the plant follow pulses.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (!stuck) begin
            if (up && floor_in != 2'd0 && floor_in != 2'd3) floor_in = floor_in + 2'd1;
            else if (down && floor_in > 2'd1) floor_in = floor_in - 2'd1;
        end
    endtask

    task automatic do_reset(input logic [1:0] fl);
        reset    = 1'b0;
        call     = 3'b000;
        floor_in = fl;
        stuck    = 1'b0;
        #1;
        model_reset();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(2'd1);
        n_checks++;
        if ({up, down, door_open, busy, fault} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 00000", {up, down, door_open, busy, fault});
        end
        n_checks++;
        if (dir_up !== 1'b1 || pending !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_dir_pending: got dir=%b pend=%b required dir=1 pend=000", dir_up, pending);
        end
    endtask

    task automatic test_up_two_floors();
        int ups = 0, downs = 0, doors = 0;
        bit done = 1'b0;
        do_reset(2'd1);
        call = 3'b100;
        tick();
        call = 3'b000;
        n_checks++;
        if (pending !== 3'b100) begin
            n_fail++;
            $display("FAIL up2_latch: got %b required 100", pending);
        end
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            if (up) ups++;
            if (down) downs++;
            if (door_open) doors++;
            if (!busy && doors > 0) done = 1'b1;
        end
        n_checks++;
        if (!done || ups != 2 || downs != 0 || doors != DOOR_CYCLES) begin
            n_fail++;
            $display("FAIL up2_sequence: got done=%0d ups=%0d downs=%0d doors=%0d required 1 2 0 %0d",
                     done, ups, downs, doors, DOOR_CYCLES);
        end
        n_checks++;
        if (floor_in !== 2'd3 || pending !== 3'b000) begin
            n_fail++;
            $display("FAIL up2_final: got floor=%0d pend=%b required floor=3 pend=000", floor_in, pending);
        end
    endtask

    task automatic test_scan_reverse();
        string seq = "";
        bit    prev_door = 1'b0;
        bit    done = 1'b0;
        bit    overlap = 1'b0;
        do_reset(2'd2);
        call = 3'b101;
        tick();
        call = 3'b000;
        for (int c = 0; c < 80 && !done; c++) begin
            tick();
            if (up && down) overlap = 1'b1;
            if (up) seq = {seq, "U"};
            if (down) seq = {seq, "D"};
            if (door_open && !prev_door) seq = {seq, $sformatf("O%0d", floor_in)};
            prev_door = door_open;
            if (!busy && pending == 3'b000) done = 1'b1;
        end
        n_checks++;
        if (!done || seq != "UO3DDO1") begin
            n_fail++;
            $display("FAIL scan_sequence: got %s (done=%0d) required UO3DDO1", seq, done);
        end
        n_checks++;
        if (dir_up !== 1'b0 || overlap) begin
            n_fail++;
            $display("FAIL scan_dir: got dir=%b overlap=%0d required dir=0 overlap=0", dir_up, overlap);
        end
    endtask

    task automatic test_door_absorb();
        int doors = 0, moves = 0, late = 0;
        do_reset(2'd1);
        call = 3'b001;
        tick();
        call = 3'b000;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (door_open) doors++;
            if (up || down) moves++;
            call = (door_open && $urandom_range(0, 1) == 1) ? 3'b001 : 3'b000;
        end
        call = 3'b000;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (door_open) late++;
        end
        n_checks++;
        if (doors != DOOR_CYCLES || moves != 0 || late != 0) begin
            n_fail++;
            $display("FAIL door_absorb: got doors=%0d moves=%0d late=%0d required %0d 0 0",
                     doors, moves, late, DOOR_CYCLES);
        end
        n_checks++;
        if (pending !== 3'b000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL door_final: got pend=%b busy=%b required 000 0", pending, busy);
        end
    endtask

    task automatic test_fault();
        logic [2:0] acc = 3'b000;
        bit         bad = 1'b0;
        do_reset(2'd1);
        floor_in = 2'd0;
        tick();
        n_checks++;
        if (fault !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_set: got fault=%b busy=%b required 1 1", fault, busy);
        end
        for (int c = 0; c < 6; c++) begin
            call = 3'($urandom_range(1, 7));
            acc  = acc | call;
            tick();
            if (up || down || door_open || !fault) bad = 1'b1;
        end
        call = 3'b000;
        tick();
        n_checks++;
        if (bad || pending !== acc) begin
            n_fail++;
            $display("FAIL fault_hold: got bad=%0d pend=%b required bad=0 pend=%b", bad, pending, acc);
        end
        reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (fault !== 1'b0 || pending !== 3'b000) begin
            n_fail++;
            $display("FAIL fault_clear: got fault=%b pend=%b required 0 000", fault, pending);
        end
        floor_in = 2'd1;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_move();
        bit seen = 1'b0;
        do_reset(2'd1);
        call = 3'b100;
        tick();
        call = 3'b000;
        for (int c = 0; c < 6 && !seen; c++) begin
            tick();
            if (up) seen = 1'b1;
        end
        reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (!seen || up !== 1'b0 || pending !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_move_reset: got seen=%0d up=%b pend=%b required 1 0 000", seen, up, pending);
        end
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || up !== 1'b0 || pending !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_move_idle: got busy=%b up=%b pend=%b required 0 0 000", busy, up, pending);
        end
    endtask

    task automatic test_stuck_repulse();
        int last = -1, pulses = 0, bad_gap = 0, downs = 0;
        do_reset(2'd1);
        stuck = 1'b1;
        call  = 3'b010;
        tick();
        call = 3'b000;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (down) downs++;
            if (up) begin
                if (last >= 0 && c - last != SETTLE_CYCLES + 2) bad_gap++;
                last = c;
                pulses++;
            end
        end
        stuck = 1'b0;
        n_checks++;
        if (pulses < 6 || bad_gap != 0 || downs != 0) begin
            n_fail++;
            $display("FAIL stuck_repulse: got pulses=%0d bad_gaps=%0d downs=%0d required >=6 0 0",
                     pulses, bad_gap, downs);
        end
        n_checks++;
        if (pending !== 3'b010) begin
            n_fail++;
            $display("FAIL stuck_pending: got %b required 010", pending);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset(2'($urandom_range(1, 3)));
        for (int c = 0; c < 600; c++) begin
            call  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            stuck = ($urandom_range(0, 9) == 0);
            tick();
            n_checks++;
            if (up !== exp_up() || down !== exp_dn() || door_open !== exp_door() ||
                busy !== exp_busy() || fault !== m_fault || dir_up !== m_dir ||
                pending !== m_pend || (up && down)) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle%0d: got up=%b dn=%b door=%b busy=%b flt=%b dir=%b pend=%b required %b %b %b %b %b %b %b",
                             c, up, down, door_open, busy, fault, dir_up, pending,
                             exp_up(), exp_dn(), exp_door(), exp_busy(), m_fault, m_dir, m_pend);
            end
        end
        call  = 3'b000;
        stuck = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_up_two_floors();
        test_scan_reverse();
        test_door_absorb();
        test_fault();
        test_reset_mid_move();
        test_stuck_repulse();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
